// File: rtl/segasys1_mainio.sv
// segasys1_mainio: main-CPU I/O block for the System 1 family.
// Decodes Z80 I/O cycles for player inputs, DIP switches, the video-mode
// latch and a sound-command FIFO, and generates the main-CPU clock enable.
module segasys1_mainio #(
  parameter int NUM_IN  = 3,
  parameter int DEPTH   = 4,
  parameter int CLK_DIV = 16
) (
  input  logic                      CLK48M,
  input  logic                      RESET,
  input  logic [7:0]                CPUAD,
  input  logic [7:0]                CPUDO,
  input  logic                      CPUIORQ,
  input  logic                      CPURD,
  input  logic                      CPUWR,
  input  logic [8*NUM_IN-1:0]       INP,
  input  logic [7:0]                DSW0,
  input  logic [7:0]                DSW1,
  output logic                      DV,
  output logic [7:0]                OD,
  output logic [7:0]                VIDMD,
  output logic [7:0]                SNDNO,
  output logic                      SNDRQ,
  input  logic                      SNDACK,
  output logic [$clog2(DEPTH):0]    SNDLVL,
  output logic                      SNDOVF,
  output logic                      CPUCE
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(CLK_DIV);

  // Bus qualification and address classes
  logic       rd_q;
  logic       wq;
  logic       wq_d;
  logic       wr_ev;
  logic       vid_sel;
  logic       snd_sel;
  logic [2:0] idx;

  // Sound-command FIFO state
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [LW-1:0] count;
  logic          full;
  logic          push;
  logic          pop;
  logic          wr_en;

  // Clock-enable divider
  logic [CW-1:0] ce_cnt;
  logic          ce_wrap;

  assign rd_q    = CPUIORQ & CPURD;
  assign wq      = CPUIORQ & CPUWR;
  assign idx     = CPUAD[4:2];
  assign vid_sel = (CPUAD == 8'h15) || (CPUAD == 8'h19);
  assign snd_sel = (CPUAD == 8'h14) || (CPUAD == 8'h18);

  // One event per bus write, on the cycle the strobe first rises.
  assign wr_ev = wq & ~wq_d & ~RESET;

  assign full  = (count == LW'(DEPTH));
  assign push  = wr_ev & snd_sel;
  assign pop   = SNDACK & (count != '0);
  // A full FIFO still takes the new byte when the head is popped on the same edge.
  assign wr_en = push & (~full | pop);

  assign SNDRQ  = (count != '0);
  assign SNDLVL = count;
  assign SNDNO  = (count == '0) ? 8'h00 : mem[rd_ptr];

  assign ce_wrap = (ce_cnt == CW'(CLK_DIV - 1));

  // Read mux: video-mode readback wins over the port decode.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    DV = 1'b0;
    OD = 8'hFF;
    if (rd_q) begin
      if (vid_sel) begin
        DV = 1'b1;
        OD = VIDMD;
      end else if (idx < 3'(NUM_IN)) begin
        DV = 1'b1;
        for (int n = 0; n < NUM_IN; n++) begin
          if (idx == 3'(n)) OD = INP[8*n +: 8];
        end
      end else if (idx == 3'(NUM_IN)) begin
        DV = 1'b1;
        OD = CPUAD[0] ? DSW1 : DSW0;
      end else if (idx == 3'(NUM_IN + 1)) begin
        DV = 1'b1;
        OD = DSW1;
      end
    end
  end

  // Delayed write strobe; it tracks the strobe even in reset, so a strobe held
  // across reset release is not mistaken for a new bus cycle.
  always_ff @(posedge CLK48M) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    wq_d <= wq;
  end

  // Video-mode latch.
  always_ff @(posedge CLK48M) begin
    if (RESET) begin
      VIDMD <= 8'h00;
    end else if (wr_ev && vid_sel) begin
      VIDMD <= CPUDO;
    end
  end

  // FIFO storage.
  always_ff @(posedge CLK48M) begin
    // NOTE: the buffer has no reset; SNDNO is masked to zero while the FIFO is empty instead.
    if (wr_en) mem[wr_ptr] <= CPUDO;
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge CLK48M) begin
    if (RESET) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      SNDOVF <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (push && full && !pop) SNDOVF <= 1'b1;
      if (wr_en && !pop)       count <= count + 1'b1;
      else if (pop && !wr_en)  count <= count - 1'b1;
    end
  end

  // CPU clock-enable divider; CPUCE follows the wrapping edge by one cycle.
  always_ff @(posedge CLK48M) begin
    if (RESET) begin
      ce_cnt <= '0;
      CPUCE  <= 1'b0;
    end else begin
      CPUCE  <= ce_wrap;
      ce_cnt <= ce_wrap ? '0 : ce_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_segasys1_mainio.sv
// tb_segasys1_mainio: randomized and directed bench for segasys1_mainio with a
// queue-based reference model and a scoreboard monitor for reads and sound pops.
module tb_segasys1_mainio;

  localparam int NUM_IN  = 3;
  localparam int DEPTH   = 4;
  localparam int CLK_DIV = 16;
  localparam int LW      = $clog2(DEPTH) + 1;

  logic                  CLK48M = 1'b0;
  logic                  RESET  = 1'b1;
  logic [7:0]            CPUAD  = 8'h00;
  logic [7:0]            CPUDO  = 8'h00;
  logic                  CPUIORQ = 1'b0;
  logic                  CPURD  = 1'b0;
  logic                  CPUWR  = 1'b0;
  logic [8*NUM_IN-1:0]   INP    = '0;
  logic [7:0]            DSW0   = 8'h00;
  logic [7:0]            DSW1   = 8'h00;
  logic                  SNDACK = 1'b0;
  logic                  DV;
  logic [7:0]            OD;
  logic [7:0]            VIDMD;
  logic [7:0]            SNDNO;
  logic                  SNDRQ;
  logic [LW-1:0]         SNDLVL;
  logic                  SNDOVF;
  logic                  CPUCE;

  segasys1_mainio #(.NUM_IN(NUM_IN), .DEPTH(DEPTH), .CLK_DIV(CLK_DIV)) dut (
    .CLK48M(CLK48M), .RESET(RESET), .CPUAD(CPUAD), .CPUDO(CPUDO),
    .CPUIORQ(CPUIORQ), .CPURD(CPURD), .CPUWR(CPUWR), .INP(INP),
    .DSW0(DSW0), .DSW1(DSW1), .DV(DV), .OD(OD), .VIDMD(VIDMD),
    .SNDNO(SNDNO), .SNDRQ(SNDRQ), .SNDACK(SNDACK), .SNDLVL(SNDLVL),
    .SNDOVF(SNDOVF), .CPUCE(CPUCE)
  );

  always #5 CLK48M = ~CLK48M;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [7:0] model_fifo[$];
  logic       model_ovf = 1'b0;
  logic [7:0] model_vid = 8'h00;

  // Scoreboard queues: {dv, od} per read, expected SNDNO per effective ack
  logic [8:0] rd_exp[$];
  logic [7:0] snd_exp[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] ref_read(input logic [7:0] a);
    int i;
    i = int'(a[4:2]);
    if (a == 8'h15 || a == 8'h19) return {1'b1, model_vid};
    if (i < NUM_IN)               return {1'b1, INP[8*i +: 8]};
    if (i == NUM_IN)              return {1'b1, (a[0] ? DSW1 : DSW0)};
    if (i == NUM_IN + 1)          return {1'b1, DSW1};
    return {1'b0, 8'hFF};
  endfunction

  task automatic model_reset();
    model_fifo.delete();
    model_ovf = 1'b0;
    model_vid = 8'h00;
  endtask

  task automatic model_write(input logic [7:0] a, input logic [7:0] d, input bit ack);
    bit do_push, do_pop;
    if (a == 8'h15 || a == 8'h19) model_vid = d;
    do_push = (a == 8'h14 || a == 8'h18);
    do_pop  = ack && (model_fifo.size() > 0);
    if (do_pop) snd_exp.push_back(model_fifo.pop_front());
    if (do_push) begin
      if (model_fifo.size() >= DEPTH) model_ovf = 1'b1;
      else model_fifo.push_back(d);
    end
  endtask

  task automatic check_state(input string name);
    check({name, "_lvl"}, SNDLVL, model_fifo.size());
    check({name, "_rq"},  SNDRQ,  model_fifo.size() != 0);
    check({name, "_no"},  SNDNO,  (model_fifo.size() != 0) ? model_fifo[0] : 8'h00);
    check({name, "_ovf"}, SNDOVF, model_ovf);
    check({name, "_vid"}, VIDMD,  model_vid);
  endtask

  // Monitor: compares DUT read data and the head popped by each ack.
  always @(negedge CLK48M) begin
    if (CPUIORQ && CPURD) begin
      if (rd_exp.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: read with no expectation at %0t", $time);
      end else begin
        logic [8:0] e;
        e = rd_exp.pop_front();
        check("rd_dv", DV, e[8]);
        check("rd_od", OD, e[7:0]);
      end
    end
    if (SNDACK) begin
      if (snd_exp.size() == 0) begin
        check("ack_empty_rq", SNDRQ, 1'b0);
      end else begin
        logic [7:0] s;
        s = snd_exp.pop_front();
        check("ack_rq", SNDRQ, 1'b1);
        check("ack_no", SNDNO, s);
      end
    end
  end

  task automatic tick();
    @(posedge CLK48M);
    #1;
  endtask

  task automatic do_reset(input int cyc);
    tick();
    RESET = 1'b1;
    model_reset();
    for (int i = 0; i < cyc; i++) tick();
    check("rst_ce", CPUCE, 1'b0);
    check_state("rst");
    RESET = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a);
    tick();
    CPUAD = a; CPUIORQ = 1'b1; CPURD = 1'b1;
    rd_exp.push_back(ref_read(a));
    tick();
    CPUIORQ = 1'b0; CPURD = 1'b0;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d, input int hold, input bit ack);
    tick();
    CPUAD = a; CPUDO = d; CPUIORQ = 1'b1; CPUWR = 1'b1; SNDACK = ack;
    model_write(a, d, ack);
    tick();
    SNDACK = 1'b0;
    check_state("wr");
    for (int i = 1; i < hold; i++) tick();
    if (hold > 1) check_state("wr_hold");
    CPUIORQ = 1'b0; CPUWR = 1'b0;
  endtask

  task automatic snd_ack();
    tick();
    SNDACK = 1'b1;
    if (model_fifo.size() > 0) snd_exp.push_back(model_fifo.pop_front());
    tick();
    SNDACK = 1'b0;
    check_state("ack");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] wa;
    do_reset(3);

    // Read decode with fixed inputs
    INP = {8'hC3, 8'hB2, 8'hA1};
    DSW0 = 8'hD0;
    DSW1 = 8'hD1;
    foreach (rd_exp[i]) ; // keep queue declared use simple
    bus_read(8'h00); bus_read(8'h05); bus_read(8'h08); bus_read(8'h0C);
    bus_read(8'h0D); bus_read(8'h10); bus_read(8'h1C); bus_read(8'h15);

    // Long strobes: one event each
    bus_write(8'h19, 8'h5A, 10, 1'b0);
    bus_read(8'h15);
    bus_write(8'h14, 8'h33, 10, 1'b0);
    snd_ack();

    // Overflow and drain
    do_reset(2);
    bus_write(8'h14, 8'h11, 1, 1'b0);
    bus_write(8'h18, 8'h22, 1, 1'b0);
    bus_write(8'h14, 8'h33, 1, 1'b0);
    bus_write(8'h18, 8'h44, 1, 1'b0);
    bus_write(8'h14, 8'h55, 1, 1'b0);
    for (int i = 0; i < 5; i++) snd_ack();

    // Simultaneous push and ack at full and at empty
    do_reset(2);
    bus_write(8'h14, 8'hA1, 1, 1'b0);
    bus_write(8'h14, 8'hA2, 1, 1'b0);
    bus_write(8'h14, 8'hA3, 1, 1'b0);
    bus_write(8'h14, 8'hA4, 1, 1'b0);
    bus_write(8'h18, 8'h66, 1, 1'b1);
    for (int i = 0; i < 4; i++) snd_ack();
    bus_write(8'h14, 8'h77, 1, 1'b1);
    snd_ack();

    // Clock enable cadence, then reset mid-count and restart
    do_reset(2);
    for (int k = 1; k <= 3 * CLK_DIV; k++) begin
      tick();
      check("ce", CPUCE, (k % CLK_DIV) == 0);
    end
    for (int k = 1; k <= 5; k++) tick();
    do_reset(2);
    for (int k = 1; k <= 2 * CLK_DIV; k++) begin
      tick();
      check("ce_rst", CPUCE, (k % CLK_DIV) == 0);
    end

    // Reset asserted during a held write strobe to 0x18
    bus_write(8'h19, 8'h3C, 1, 1'b0);
    tick();
    CPUAD = 8'h18; CPUDO = 8'h99; CPUIORQ = 1'b1; CPUWR = 1'b1;
    model_write(8'h18, 8'h99, 1'b0);
    tick();
    check_state("rstwr_pre");
    RESET = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) tick();
    RESET = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check_state("rstwr_post");
    CPUIORQ = 1'b0; CPUWR = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 3))
        0: begin
          INP  = {$urandom, $urandom};
          DSW0 = 8'($urandom);
          DSW1 = 8'($urandom);
          bus_read(8'($urandom));
        end
        1, 2: begin
          case ($urandom_range(0, 4))
            0: wa = 8'h14;
            1: wa = 8'h18;
            2: wa = 8'h15;
            3: wa = 8'h19;
            default: wa = 8'($urandom);
          endcase
          bus_write(wa, 8'($urandom), $urandom_range(1, 3), $urandom_range(0, 3) == 0);
        end
        default: snd_ack();
      endcase
    end

    tick();
    check("sb_rd_drain", rd_exp.size(), 0);
    check("sb_snd_drain", snd_exp.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
